// File: rtl/booth_arith_pkg.sv
// Shared arithmetic helpers for the Booth multiplier / divider pair:
// FSM state type, default width and magnitude / conditional-negate helpers.
package booth_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DEFAULT_WIDTH_DATA = 32;

  // Helpers work on a wide container; callers sign/zero-extend into it and
  // size-cast the result back to their own operand width (widths up to 127).
  localparam int MAX_WIDTH_DATA = 128;

  function automatic logic [MAX_WIDTH_DATA-1:0] abs_mag(
    input logic signed [MAX_WIDTH_DATA-1:0] v
  );
    return v[MAX_WIDTH_DATA-1] ? -v : v;
  endfunction

  function automatic logic [MAX_WIDTH_DATA-1:0] neg2c(
    input logic [MAX_WIDTH_DATA-1:0] v,
    input logic                      neg
  );
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift {prem, q} left, trial-subtract the
// divisor magnitude, keep the difference or restore.
module div_restore_step #(
  parameter int WIDTH_DATA = 32
) (
  input  logic [WIDTH_DATA:0]   prem_in,
  input  logic [WIDTH_DATA-1:0] q_in,
  input  logic [WIDTH_DATA-1:0] dvsr,
  output logic [WIDTH_DATA:0]   prem_out,
  output logic [WIDTH_DATA-1:0] q_out
);

  logic [WIDTH_DATA+1:0] shifted;
  logic [WIDTH_DATA+1:0] diff;

  always_comb begin
    shifted = {prem_in, q_in[WIDTH_DATA-1]};
    diff    = shifted - {2'b00, dvsr};
    // Top bit of the extra-wide difference is the borrow.
    if (!diff[WIDTH_DATA+1]) begin
      prem_out = diff[WIDTH_DATA:0];
      q_out    = {q_in[WIDTH_DATA-2:0], 1'b1};
    end else begin
      prem_out = shifted[WIDTH_DATA:0];
      q_out    = {q_in[WIDTH_DATA-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/booth_div_seq.sv
// Sequential signed radix-2 divider (truncating, C semantics): unsigned
// restoring core on magnitudes followed by a single sign-fix cycle.
module booth_div_seq
  import booth_arith_pkg::*;
#(
  parameter int WIDTH_DATA = DEFAULT_WIDTH_DATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH_DATA-1:0] dividend,
  input  logic [WIDTH_DATA-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [WIDTH_DATA-1:0] quotient,
  output logic [WIDTH_DATA-1:0] remainder,
  output div_state_t            dbg_state
);

  // Handshake: start is accepted only in IDLE (busy=0) and operands are
  // captured on that edge; done is a one-cycle pulse with results valid,
  // and results hold until the next accepted start loads new ones.

  localparam int CW = $clog2(WIDTH_DATA);
  localparam int XW = MAX_WIDTH_DATA - WIDTH_DATA;
  localparam logic [CW-1:0] LAST = CW'(WIDTH_DATA - 1);

  div_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH_DATA:0]   prem_q, prem_d;
  logic [WIDTH_DATA-1:0] quo_q, quo_d;
  logic [WIDTH_DATA-1:0] dvsr_q, dvsr_d;
  logic                  sign_q_q, sign_q_d;
  logic                  sign_r_q, sign_r_d;
  logic [WIDTH_DATA-1:0] quotient_q, quotient_d;
  logic [WIDTH_DATA-1:0] remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  logic [WIDTH_DATA:0]   step_prem;
  logic [WIDTH_DATA-1:0] step_q;

  div_restore_step #(.WIDTH_DATA(WIDTH_DATA)) u_step (
    .prem_in  (prem_q),
    .q_in     (quo_q),
    .dvsr     (dvsr_q),
    .prem_out (step_prem),
    .q_out    (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            sign_q_d = dividend[WIDTH_DATA-1] ^ divisor[WIDTH_DATA-1];
            sign_r_d = dividend[WIDTH_DATA-1];
            quo_d    = WIDTH_DATA'(abs_mag({{XW{dividend[WIDTH_DATA-1]}}, dividend}));
            dvsr_d   = WIDTH_DATA'(abs_mag({{XW{divisor[WIDTH_DATA-1]}}, divisor}));
            prem_d   = '0;
            cnt_d    = '0;
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        prem_d = step_prem;
        quo_d  = step_q;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        // Partial remainder is below the divisor here, so its low bits suffice.
        quotient_d  = WIDTH_DATA'(neg2c({{XW{1'b0}}, quo_q}, sign_q_q));
        remainder_d = WIDTH_DATA'(neg2c({{XW{1'b0}}, prem_q[WIDTH_DATA-1:0]}, sign_r_q));
        dbz_d       = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_booth_div_seq.sv
// Self-checking bench for booth_div_seq: latency/result model built from
// signed integer division, directed test-plan cases and random traffic.
module tb_booth_div_seq;
  import booth_arith_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  div_state_t   dbg_state;

  booth_div_seq #(.WIDTH_DATA(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed division, C truncation; /0 gives all ones and the dividend.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, qq, rr;
    logic [63:0] qv, rv;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qq = sa / sb;
    rr = sa % sb;
    qv = qq;
    rv = rr;
    return {1'b0, qv[W-1:0], rv[W-1:0]};
  endfunction

  // Behavioural timing model: results appear (and done rises) LAT-1 edges
  // after the accepting edge, or on that same edge for divide-by-zero.
  logic [2*W:0] exp_q[$];
  logic [W-1:0] m_q = '0, m_r = '0;
  logic         m_dbz = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  int           m_left = 0;

  task automatic retire();
    logic [2*W:0] e;
    e = exp_q.pop_front();
    m_dbz  = e[2*W];
    m_q    = e[2*W-1:W];
    m_r    = e[W-1:0];
    m_done = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q = '0; m_r = '0; m_dbz = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      exp_q.delete();
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) retire();
    end else if (start) begin
      exp_q.push_back(ref_div(dividend, divisor));
      m_busy = 1'b1;
      m_left = (divisor == '0) ? 0 : LAT - 1;
      if (m_left == 0) retire();
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    chk("quotient", 64'(quotient), 64'(m_q));
    chk("remainder", 64'(remainder), 64'(m_r));
  end

  // Waits at negedges for done; returns edge count since the accepting edge.
  task automatic wait_done(output int n);
    n = 1;
    forever begin
      @(negedge clk);
      if (done) break;
      if (n >= 200) begin
        chk("done_timeout", 64'(n), 64'(0));
        break;
      end
      @(posedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input int elat);
    int n;
    @(posedge clk); #2;
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    wait_done(n);
    chk({nm, "_lat"}, 64'(n), 64'(elat));
    chk({nm, "_q"}, 64'(quotient), 64'(eq));
    chk({nm, "_r"}, 64'(remainder), 64'(er));
    chk({nm, "_dbz"}, 64'(div_by_zero), 64'(edbz));
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return W'($urandom_range(0, 40)) - W'(20);
      3:       return '1;
      4:       return W'($urandom_range(0, 1000));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_q", 64'(quotient), 64'(0));
    chk("rst_r", 64'(remainder), 64'(0));
    @(posedge clk); #2;
    rst = 1'b0;

    run_op("d1000_3", 32'h3E8, 32'h3, 32'h0000014D, 32'h00000001, 1'b0, LAT);
    run_op("d27000_m200", 32'h6978, 32'hFFFFFF38, 32'hFFFFFF79, 32'h0, 1'b0, LAT);
    run_op("dm100_7", 32'hFFFFFF9C, 32'h7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, LAT);
    run_op("dm378950_m1205", 32'hFFFA37BA, 32'hFFFFFB4B, 32'h0000013A, 32'hFFFFFDBC, 1'b0, LAT);
    run_op("d5_0", 32'h5, 32'h0, 32'hFFFFFFFF, 32'h00000005, 1'b1, 1);
    run_op("dmin_m1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, LAT);
    run_op("d0_9", 32'h0, 32'h9, 32'h0, 32'h0, 1'b0, LAT);

    // Second start while busy must be ignored.
    @(posedge clk); #2;
    dividend = 32'h3E8; divisor = 32'h3; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    dividend = 32'h7; divisor = 32'h7; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(n);
    chk("busy_ign_lat", 64'(n), 64'(LAT - 9));
    chk("busy_ign_q", 64'(quotient), 64'(32'h14D));
    chk("busy_ign_r", 64'(remainder), 64'(32'h1));
    run_op("b2b_7_7", 32'h7, 32'h7, 32'h1, 32'h0, 1'b0, LAT);

    // Reset in the middle of an operation.
    @(posedge clk); #2;
    dividend = 32'h3E8; divisor = 32'h3; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_q", 64'(quotient), 64'(0));
    chk("midrst_r", 64'(remainder), 64'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    run_op("d21_m1", 32'd21, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'h0, 1'b0, LAT);

    // Random traffic, including starts during busy/DONE and operand churn.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      start    = ($urandom_range(0, 3) == 0);
      dividend = rand_operand();
      divisor  = rand_operand();
    end
    #2;
    start = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
